// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: parallel load, counted serial burst
// with stall, and a one-cycle done pulse.
module usr_bit_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic load_en,
  input  logic shift_en,
  input  logic d_bit,
  input  logic shift_bit,
  output logic q_bit
);
  always_ff @(posedge clk) begin
    if (reset)         q_bit <= RST_BIT;
    else if (load_en)  q_bit <= d_bit;
    else if (shift_en) q_bit <= shift_bit;
  end
endmodule

module universal_shift_reg #(
  parameter int               WIDTH       = 8,
  parameter bit               MSB_FIRST   = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  input  logic             start,
  input  logic             stall,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             done_r, done_n;
  logic             load_en, shift_en;
  logic [WIDTH-1:0] shift_src;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    done_n   = 1'b0;
    load_en  = 1'b0;
    shift_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_en = 1'b1;
          cnt_n   = '0;
          state_n = SHIFT;
        end else if (load) begin
          load_en = 1'b1;
        end
      end
      SHIFT: begin
        // start/load are deliberately dropped while a burst is running
        if (!stall) begin
          shift_en = 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state_n = IDLE;
            cnt_n   = '0;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      done_r <= done_n;
    end
  end

  generate
    if (MSB_FIRST) begin : g_msb
      assign shift_src = {q[WIDTH-2:0], ser_in};
      assign ser_out   = q[WIDTH-1];
    end else begin : g_lsb
      assign shift_src = {ser_in, q[WIDTH-1:1]};
      assign ser_out   = q[0];
    end
  endgenerate

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      usr_bit_cell #(.RST_BIT(RESET_VALUE[i])) u_cell (
        .clk      (clk),
        .reset    (reset),
        .load_en  (load_en),
        .shift_en (shift_en),
        .d_bit    (d[i]),
        .shift_bit(shift_src[i]),
        .q_bit    (q[i])
      );
    end
  endgenerate

  assign busy = (state == SHIFT);
  assign done = done_r;
endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: an 8-bit MSB-first instance and a 4-bit
// LSB-first instance driven from per-cycle vector records.
module tb_universal_shift_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, ld8, st8, stl8, si8, so8, busy8, done8;
  logic [7:0] d8, q8;
  logic       rst4, ld4, st4, stl4, si4, so4, busy4, done4;
  logic [3:0] d4, q4;

  universal_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1), .RESET_VALUE(8'hA5)) u_dut8 (
    .clk(clk), .reset(rst8), .d(d8), .load(ld8), .start(st8), .stall(stl8),
    .ser_in(si8), .ser_out(so8), .q(q8), .busy(busy8), .done(done8)
  );

  universal_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b0), .RESET_VALUE(4'h0)) u_dut4 (
    .clk(clk), .reset(rst4), .d(d4), .load(ld4), .start(st4), .stall(stl4),
    .ser_in(si4), .ser_out(so4), .q(q4), .busy(busy4), .done(done4)
  );

  typedef struct {
    logic       rst, ld, st, stl;
    logic [7:0] d;
    logic       si;
    logic [7:0] q;
    logic       so, busy, done;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t sb[$];

  function automatic vec_t mk(logic rst, logic ld, logic st, logic stl, logic [7:0] d,
                              logic si, logic [7:0] q, logic so, logic busy, logic done);
    vec_t v;
    v.rst = rst; v.ld = ld; v.st = st; v.stl = stl; v.d = d; v.si = si;
    v.q = q; v.so = so; v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, queue the expected post-edge state, compare after the edge.
  task automatic apply8(input vec_t v, input string tag);
    vec_t e;
    rst8 = v.rst; ld8 = v.ld; st8 = v.st; stl8 = v.stl; d8 = v.d; si8 = v.si;
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, ".q"},    q8,           e.q);
    chk({tag, ".so"},   {7'd0, so8},  {7'd0, e.so});
    chk({tag, ".busy"}, {7'd0, busy8}, {7'd0, e.busy});
    chk({tag, ".done"}, {7'd0, done8}, {7'd0, e.done});
  endtask

  task automatic apply4(input vec_t v, input string tag);
    vec_t e;
    rst4 = v.rst; ld4 = v.ld; st4 = v.st; stl4 = v.stl; d4 = v.d[3:0]; si4 = v.si;
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, ".q"},    {4'd0, q4},    e.q);
    chk({tag, ".so"},   {7'd0, so4},   {7'd0, e.so});
    chk({tag, ".busy"}, {7'd0, busy4}, {7'd0, e.busy});
    chk({tag, ".done"}, {7'd0, done4}, {7'd0, e.done});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl8[$];
    vec_t tbl4[$];
    logic [7:0] eq;

    // rst ld st stl d si | q so busy done
    tbl8.push_back(mk(1,0,0,0,8'h00,0, 8'hA5,1,0,0));  // reset
    tbl8.push_back(mk(0,1,0,0,8'h3C,0, 8'h3C,0,0,0));  // load
    tbl8.push_back(mk(0,0,0,0,8'hFF,0, 8'h3C,0,0,0));  // hold
    tbl8.push_back(mk(0,0,0,1,8'hFF,0, 8'h3C,0,0,0));  // stall in idle
    tbl8.push_back(mk(0,1,1,0,8'h81,0, 8'h81,1,1,0));  // start wins over load
    tbl8.push_back(mk(0,1,0,0,8'hFF,0, 8'h02,0,1,0));  // load ignored while busy
    tbl8.push_back(mk(0,0,1,0,8'hFF,0, 8'h04,0,1,0));  // start ignored while busy
    tbl8.push_back(mk(0,0,0,0,8'h00,0, 8'h08,0,1,0));
    tbl8.push_back(mk(0,0,0,0,8'h00,0, 8'h10,0,1,0));
    tbl8.push_back(mk(0,0,0,0,8'h00,0, 8'h20,0,1,0));
    tbl8.push_back(mk(0,0,0,0,8'h00,0, 8'h40,0,1,0));
    tbl8.push_back(mk(0,0,0,0,8'h00,0, 8'h80,1,1,0));
    tbl8.push_back(mk(0,0,0,0,8'h00,0, 8'h00,0,0,1));  // done
    tbl8.push_back(mk(0,0,1,0,8'hB4,0, 8'hB4,1,1,0));  // back-to-back start
    tbl8.push_back(mk(0,0,0,0,8'h00,1, 8'h69,0,1,0));
    tbl8.push_back(mk(0,0,0,0,8'h00,0, 8'hD2,1,1,0));
    tbl8.push_back(mk(0,0,0,0,8'h00,1, 8'hA5,1,1,0));
    tbl8.push_back(mk(0,0,0,0,8'h00,1, 8'h4B,0,1,0));
    tbl8.push_back(mk(0,0,0,0,8'h00,0, 8'h96,1,1,0));
    tbl8.push_back(mk(0,0,0,0,8'h00,0, 8'h2C,0,1,0));
    tbl8.push_back(mk(0,0,0,0,8'h00,1, 8'h59,0,1,0));
    tbl8.push_back(mk(0,0,0,0,8'h00,0, 8'hB2,1,0,1));  // done at k+8
    tbl8.push_back(mk(0,0,0,0,8'h00,0, 8'hB2,1,0,0));  // done drops

    tbl4.push_back(mk(1,0,0,0,8'h00,0, 8'h00,0,0,0));
    tbl4.push_back(mk(0,0,1,0,8'h06,1, 8'h06,0,1,0));
    tbl4.push_back(mk(0,0,0,0,8'h00,1, 8'h0B,1,1,0));
    tbl4.push_back(mk(0,0,0,0,8'h00,1, 8'h0D,1,1,0));
    tbl4.push_back(mk(0,0,0,0,8'h00,1, 8'h0E,0,1,0));
    tbl4.push_back(mk(0,0,0,0,8'h00,1, 8'h0F,1,0,1));  // done at k+4
    tbl4.push_back(mk(0,0,0,0,8'h00,1, 8'h0F,1,0,0));

    rst8 = 1'b1; ld8 = 0; st8 = 0; stl8 = 0; d8 = '0; si8 = 0;
    rst4 = 1'b1; ld4 = 0; st4 = 0; stl4 = 0; d4 = '0; si4 = 0;
    @(negedge clk);

    for (int i = 0; i < tbl8.size(); i++) apply8(tbl8[i], $sformatf("v8[%0d]", i));
    for (int i = 0; i < tbl4.size(); i++) apply4(tbl4[i], $sformatf("v4[%0d]", i));

    // Stall for three cycles after two shifts; done lands at k+11.
    apply8(mk(0,0,1,0,8'hC3,0, 8'hC3,1,1,0), "stall.start");
    apply8(mk(0,0,0,0,8'h00,0, 8'h86,1,1,0), "stall.s1");
    apply8(mk(0,0,0,0,8'h00,0, 8'h0C,0,1,0), "stall.s2");
    apply8(mk(0,0,0,1,8'h00,1, 8'h0C,0,1,0), "stall.h1");
    apply8(mk(0,0,1,1,8'h00,1, 8'h0C,0,1,0), "stall.h2");
    apply8(mk(0,1,0,1,8'hFF,1, 8'h0C,0,1,0), "stall.h3");
    apply8(mk(0,0,0,0,8'h00,0, 8'h18,0,1,0), "stall.s3");
    apply8(mk(0,0,0,0,8'h00,0, 8'h30,0,1,0), "stall.s4");
    apply8(mk(0,0,0,0,8'h00,0, 8'h60,0,1,0), "stall.s5");
    apply8(mk(0,0,0,0,8'h00,0, 8'hC0,1,1,0), "stall.s6");
    apply8(mk(0,0,0,0,8'h00,0, 8'h80,1,1,0), "stall.s7");
    apply8(mk(0,0,0,0,8'h00,0, 8'h00,0,0,1), "stall.s8");

    // Reset after three shifts aborts the burst without a done pulse.
    apply8(mk(0,0,1,0,8'h5A,1, 8'h5A,0,1,0), "abort.start");
    apply8(mk(0,0,0,0,8'h00,1, 8'hB5,1,1,0), "abort.s1");
    apply8(mk(0,0,0,0,8'h00,1, 8'h6B,0,1,0), "abort.s2");
    apply8(mk(0,0,0,0,8'h00,1, 8'hD7,1,1,0), "abort.s3");
    apply8(mk(1,0,1,0,8'h33,1, 8'hA5,1,0,0), "abort.reset");
    apply8(mk(0,0,0,0,8'h00,1, 8'hA5,1,0,0), "abort.idle");

    apply8(mk(0,0,1,0,8'hFF,0, 8'hFF,1,1,0), "ff.start");
    for (int j = 1; j <= 8; j++) begin
      eq = 8'hFF << j;
      apply8(mk(0,0,0,0,8'h00,0, eq, eq[7], (j < 8), (j == 8)), $sformatf("ff.s%0d", j));
    end
    apply8(mk(0,0,0,0,8'h00,0, 8'h00,0,0,0), "ff.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised shift register that generalises the single-bit D flip-flop into a WIDTH-bit register with parallel load, a counted serial shift burst, stall and done signalling. It is the serialiser/deserialiser building block for the team's serial-link and test-pattern modules: a word is loaded in parallel, shifted out one bit per clock while incoming serial bits are captured, and the captured word is read back in parallel.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- MSB_FIRST, 1, 1: shift left, ser_out = q[WIDTH-1], ser_in enters q[0]; 0: shift right, ser_out = q[0], ser_in enters q[WIDTH-1].
- RESET_VALUE, 0, value loaded into q on reset (WIDTH bits).

- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- d  input  WIDTH  parallel data for load/start.
- load  input  1  parallel load without shifting (IDLE only).
- start  input  1  parallel load d, then shift WIDTH bits (IDLE only).
- stall  input  1  pause the shift burst for this cycle.
- ser_in  input  1  serial data captured on each shift.
- ser_out  output  1  serial data out, combinational from q per MSB_FIRST.
- q  output  WIDTH  register contents.
- busy  output  1  high while in SHIFT state.
- done  output  1  one-cycle pulse after the final shift.

## Operation
- States: IDLE, SHIFT. Internal counter cnt, width $clog2(WIDTH+1), counts completed shifts.
- Reset (reset=1 at an edge, overrides all inputs): state=IDLE, q=RESET_VALUE, cnt=0, busy=0, done=0.
- IDLE:
  - start=1: q<=d, cnt<=0, state<=SHIFT. start has priority over load.
  - load=1, start=0: q<=d, stay IDLE, no done.
  - Neither: q holds.
- SHIFT:
  - stall=1: q, cnt hold; state stays SHIFT.
  - stall=0: q shifts one position (direction per MSB_FIRST), ser_in inserted at vacated end; cnt<=cnt+1.
  - When a shift is performed with cnt==WIDTH-1: state<=IDLE, cnt<=0, done<=1.
  - start and load are ignored in SHIFT (no queuing).
- done is registered and high for exactly one cycle; cleared on every other edge.
- busy = (state==SHIFT), registered.
- After a full burst q holds the WIDTH captured ser_in bits: first captured bit in q[WIDTH-1] when MSB_FIRST=1, in q[0] when MSB_FIRST=0.

## Timing
- start sampled at edge k: q=d and busy=1 from k; ser_out presents the first bit (d[WIDTH-1] if MSB_FIRST) during cycle k..k+1.
- Without stall: shifts occur at edges k+1..k+WIDTH; ser_out bit i valid during cycle k+i..k+i+1; ser_in sampled at each shift edge.
- Edge k+WIDTH: busy=0, done=1; edge k+WIDTH+1: done=0. Total burst latency WIDTH+1 edges including the start edge; each stalled cycle adds one.
- start may be asserted in the done cycle (state already IDLE) and begins a back-to-back burst with no gap.
- load: q updated one edge after sampling; ser_out follows combinationally.
- Reset mid-burst: next edge forces IDLE, q=RESET_VALUE, done stays 0 (no done pulse for aborted burst).
- stall in IDLE: no effect.

## Test plan
- Reset: RESET_VALUE=8'hA5, reset=1 one edge -> q=8'hA5, busy=0, done=0, ser_out=1 (MSB_FIRST=1).
- Load: IDLE, load=1, d=8'h3C -> next edge q=8'h3C, busy=0, done never pulses; start=1 with load=1, d=8'h81 -> burst starts, busy=1.
- Burst MSB_FIRST=1: start with d=8'hB4, ser_in pattern 1,0,1,1,0,0,1,0 -> ser_out sequence 1,0,1,1,0,1,0,0; done pulses exactly at edge k+8; final q=8'hB2.
- Burst MSB_FIRST=0, WIDTH=4: start d=4'b0110, ser_in constant 1 -> ser_out 0,1,1,0; final q=4'hF; done at edge k+4.
- Stall: WIDTH=8, stall=1 for 3 cycles mid-burst -> ser_out holds bit during stall, done at edge k+11; start during busy ignored (q unaffected).
- Reset mid-burst after 3 shifts -> next edge q=RESET_VALUE, busy=0, no done; then start d=8'hFF completes normally with done at k+8.
